// File: rtl/shiftreg_dyn.sv
// Multi-lane, stall-aware delay line with a run-time programmable depth (0..MAXDELAY).
// Define SHIFTREG_DATA_RST_EN to clear the data array on reset as well as the valid tags.
module shiftreg_dyn #(
    parameter int unsigned LOGQ          = 32,
    parameter int unsigned LANES         = 1,
    parameter int unsigned MAXDELAY      = 16,
    parameter int unsigned DEFAULT_DELAY = 0,
    parameter int unsigned DW            = $clog2(MAXDELAY + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  delay_ld,
    input  logic [DW-1:0]         delay_i,
    input  logic                  in_valid,
    input  logic [LANES*LOGQ-1:0] data_in,
    output logic                  out_valid,
    output logic [LANES*LOGQ-1:0] data_out,
    output logic                  busy,
    output logic [DW-1:0]         cur_delay
);

    localparam int unsigned DATA_W = LANES * LOGQ;
    localparam int unsigned PW     = (MAXDELAY > 1) ? $clog2(MAXDELAY) : 1;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       wp_q, wp_d;
    logic [DW-1:0]       cur_delay_q, cur_delay_d;
    logic [DW-1:0]       fill_cnt_q, fill_cnt_d;
    logic [MAXDELAY-1:0] valid_q;
    logic [DATA_W-1:0]   mem_q [MAXDELAY];

    logic [DW-1:0]       ld_delay;
    logic [PW-1:0]       rd_ptr;

    assign ld_delay = (32'(delay_i) > MAXDELAY) ? DW'(MAXDELAY) : delay_i;

    // Head slot is (wp - D) mod MAXDELAY; D == MAXDELAY lands on wp itself.
    always_comb begin
        if (32'(wp_q) >= 32'(cur_delay_q)) begin
            rd_ptr = PW'(32'(wp_q) - 32'(cur_delay_q));
        end else begin
            rd_ptr = PW'(32'(wp_q) + MAXDELAY - 32'(cur_delay_q));
        end
    end

    // Next-state: a load restarts the fill, and an enabled edge counts as one fill step.
    always_comb begin
        wp_d        = wp_q;
        cur_delay_d = cur_delay_q;
        fill_cnt_d  = fill_cnt_q;
        state_d     = state_q;
        if (en) begin
            wp_d = (wp_q == PW'(MAXDELAY - 1)) ? '0 : wp_q + PW'(1);
        end
        if (delay_ld) begin
            cur_delay_d = ld_delay;
            fill_cnt_d  = ld_delay;
        end
        if (en && (fill_cnt_d != '0)) begin
            fill_cnt_d = fill_cnt_d - DW'(1);
        end
        state_d = (fill_cnt_d == '0) ? ST_RUN : ST_FILL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q        <= '0;
            cur_delay_q <= DW'(DEFAULT_DELAY);
            fill_cnt_q  <= DW'(DEFAULT_DELAY);
            state_q     <= (DEFAULT_DELAY != 0) ? ST_FILL : ST_RUN;
        end else begin
            wp_q        <= wp_d;
            cur_delay_q <= cur_delay_d;
            fill_cnt_q  <= fill_cnt_d;
            state_q     <= state_d;
        end
    end

    // Flush clears every tag first; the same-edge write then lands on top of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (delay_ld) begin
                valid_q <= '0;
            end
            if (en) begin
                valid_q[wp_q] <= in_valid;
            end
        end
    end

`ifdef SHIFTREG_DATA_RST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MAXDELAY); i++) begin
                mem_q[i] <= '0;
            end
        end else if (en) begin
            mem_q[wp_q] <= data_in;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[wp_q] <= data_in;
        end
    end
`endif

    // Zero delay bypasses the array entirely.
    always_comb begin
        if (cur_delay_q == '0) begin
            out_valid = en & in_valid;
            data_out  = data_in;
        end else begin
            out_valid = en & valid_q[rd_ptr];
            data_out  = mem_q[rd_ptr];
        end
    end

    assign busy      = (state_q == ST_FILL);
    assign cur_delay = cur_delay_q;

endmodule

// File: tb/tb_shiftreg_dyn.sv
// Randomised bench for shiftreg_dyn against a queue-based model of the delay line.
module tb_shiftreg_dyn;

    localparam int LOGQ          = 32;
    localparam int LANES         = 2;
    localparam int MAXDELAY      = 16;
    localparam int DEFAULT_DELAY = 5;
    localparam int DW            = $clog2(MAXDELAY + 1);
    localparam int DATA_W        = LANES * LOGQ;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              delay_ld;
    logic [DW-1:0]     delay_i;
    logic              in_valid;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic [DW-1:0]     cur_delay;

    int total = 0;
    int bad   = 0;

    shiftreg_dyn #(
        .LOGQ(LOGQ), .LANES(LANES), .MAXDELAY(MAXDELAY), .DEFAULT_DELAY(DEFAULT_DELAY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .delay_ld(delay_ld), .delay_i(delay_i),
        .in_valid(in_valid), .data_in(data_in), .out_valid(out_valid),
        .data_out(data_out), .busy(busy), .cur_delay(cur_delay)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: history of accepted samples, newest at the back; a load clears all tags.
    bit                hv[$];
    logic [DATA_W-1:0] hd[$];
    int                m_delay = DEFAULT_DELAY;
    int                m_fill  = DEFAULT_DELAY;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hv.delete();
            hd.delete();
            m_delay = DEFAULT_DELAY;
            m_fill  = DEFAULT_DELAY;
        end else begin
            if (delay_ld) begin
                m_delay = (int'(delay_i) > MAXDELAY) ? MAXDELAY : int'(delay_i);
                foreach (hv[i]) hv[i] = 1'b0;
                m_fill = m_delay;
            end
            if (en) begin
                hv.push_back(in_valid);
                hd.push_back(data_in);
                if (hv.size() > MAXDELAY) begin
                    void'(hv.pop_front());
                    void'(hd.pop_front());
                end
                if (m_fill > 0) m_fill--;
            end
        end
    end

    // Compare process: outputs are checked every out-of-reset cycle at the falling edge.
    always @(negedge clk) begin
        logic              exp_v;
        logic [DATA_W-1:0] exp_d;
        if (rst_n === 1'b1) begin
            exp_v = 1'b0;
            exp_d = '0;
            if (m_delay == 0) begin
                exp_v = en & in_valid;
                exp_d = data_in;
            end else if (hv.size() >= m_delay) begin
                exp_v = en & hv[hv.size() - m_delay];
                exp_d = hd[hv.size() - m_delay];
            end
            chk("out_valid", 64'(out_valid), 64'(exp_v));
            if (exp_v) chk("data_out", data_out, exp_d);
            chk("busy", 64'(busy), 64'(m_fill > 0));
            chk("cur_delay", 64'(cur_delay), 64'(m_delay));
        end
    end

    task automatic cyc(input logic e, input logic ld, input int d, input logic iv,
                       input logic [DATA_W-1:0] dat);
        @(posedge clk);
        #1;
        en       = e;
        delay_ld = ld;
        delay_i  = DW'(d);
        in_valid = iv;
        data_in  = dat;
        #2;
    endtask

    task automatic rnd_cyc(input int ld_odds);
        logic ld;
        ld = ($urandom_range(ld_odds - 1) == 0);
        cyc(1'($urandom), ld, int'($urandom_range(31)), 1'($urandom), {$urandom, $urandom});
    endtask

    initial begin
        bit pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        rst_n = 1'b0; en = 1'b0; delay_ld = 1'b0; delay_i = '0; in_valid = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset cur_delay", 64'(cur_delay), 64'd5);
        chk("reset busy", 64'(busy), 64'd1);
        rst_n = 1'b1;

        // Ramp at the default delay of 5.
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b1, 1'b0, 0, 1'b1, {32'(k + 1000), 32'(k)});
            if (k == 5) begin
                chk("ramp k5 out_valid", 64'(out_valid), 64'd0);
                chk("ramp k5 busy", 64'(busy), 64'd1);
            end
            if (k == 6) begin
                chk("ramp k6 out_valid", 64'(out_valid), 64'd1);
                chk("ramp k6 lane0", 64'(data_out[31:0]), 64'd1);
                chk("ramp k6 busy", 64'(busy), 64'd0);
            end
            if (k == 12) begin
                chk("ramp k12 lane0", 64'(data_out[31:0]), 64'd7);
                chk("ramp k12 lane1", 64'(data_out[63:32]), 64'd1007);
            end
        end

        // Stalls at D=4, long enough to wrap the write pointer several times.
        cyc(1'b1, 1'b1, 4, 1'b1, {$urandom, $urandom});
        for (int k = 0; k < 60; k++) begin
            cyc(1'($urandom), 1'b0, 0, 1'b1, {$urandom, $urandom});
            if (!en) chk("stall out_valid", 64'(out_valid), 64'd0);
        end
        chk("stall cur_delay", 64'(cur_delay), 64'd4);

        // Reload from 3 to 7, then an over-range request clamps to 16.
        cyc(1'b1, 1'b1, 3, 1'b1, {$urandom, $urandom});
        repeat (10) cyc(1'b1, 1'b0, 0, 1'b1, {$urandom, $urandom});
        cyc(1'b1, 1'b1, 7, 1'b1, {$urandom, $urandom});
        cyc(1'b1, 1'b0, 0, 1'b1, {$urandom, $urandom});
        chk("reload cur_delay", 64'(cur_delay), 64'd7);
        chk("reload out_valid", 64'(out_valid), 64'd0);
        repeat (12) cyc(1'($urandom), 1'b0, 0, 1'b1, {$urandom, $urandom});
        cyc(1'b1, 1'b1, 20, 1'b1, {$urandom, $urandom});
        cyc(1'b1, 1'b0, 0, 1'b1, {$urandom, $urandom});
        chk("clamp cur_delay", 64'(cur_delay), 64'd16);
        repeat (40) cyc(1'($urandom), 1'b0, 0, 1'($urandom), {$urandom, $urandom});

        // Pass-through at D=0.
        cyc(1'b1, 1'b1, 0, 1'b0, '0);
        cyc(1'b1, 1'b0, 0, 1'b1, 64'h1234_5678_9abc_def0);
        chk("d0 out_valid", 64'(out_valid), 64'd1);
        chk("d0 data_out", data_out, 64'h1234_5678_9abc_def0);
        chk("d0 busy", 64'(busy), 64'd0);
        repeat (20) cyc(1'($urandom), 1'b0, 0, 1'($urandom), {$urandom, $urandom});

        // Valid-gap pattern at D=2, starting on the load edge.
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, (i == 0), 2, pat[i], {$urandom, $urandom});
            if (i >= 2) chk("gap out_valid", 64'(out_valid), 64'(pat[i - 2]));
        end

        // Mixed random traffic with occasional reloads.
        repeat (400) rnd_cyc(16);

        // Asynchronous reset mid-stream.
        cyc(1'b1, 1'b0, 0, 1'b1, {$urandom, $urandom});
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst cur_delay", 64'(cur_delay), 64'd5);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) rnd_cyc(32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
